// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds a single-bit adder cell LSB-first through a registered carry.
// Define SERIAL_ADD_SUB_EN to add the `sub` port (a - b, cout=1 means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic             r_sub;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_sub;
  logic             w_carry_init;
  logic             w_cell_b;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the start carry is forced high and cin is ignored.
  assign w_carry_init = w_sub ? 1'b1 : cin;
  assign w_accept     = start && (r_state != S_RUN);

  // Single-bit adder cell (generate/propagate form).
  assign w_cell_b   = r_b[0] ^ r_sub;
  assign w_s        = r_a[0] ^ w_cell_b ^ r_carry;
  assign w_cout     = (r_a[0] & w_cell_b) | ((r_a[0] ^ w_cell_b) & r_carry);
  assign w_acc_next = {w_s, r_acc};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_count == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset too; at this width it is cheap and keeps sum/cout defined.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= w_carry_init;
        r_sub   <= w_sub;
        r_count <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_cout;
        r_acc   <= w_acc_next[WIDTH-1:1];
        if (r_count == LAST) begin
          // Publish only the completed result; partial sums never reach the outputs.
          r_sum  <= w_acc_next;
          r_cout <= w_cout;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); define SERIAL_ADD_SUB_EN to cover subtraction too.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Counts negedges until done, starting from a given count; bounded so a stuck DUT still ends.
  task automatic wait_done(input int start_cyc, output int cyc, output int busy_cyc);
    cyc      = start_cyc;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_ops(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    a   = ta;
    b   = tb_;
    cin = tc;
`ifdef SERIAL_ADD_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub requested in add-only build");
`endif
  endtask

  task automatic do_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic ts, input logic [7:0] es, input logic ec);
    int cyc, bcyc;
    @(negedge clk);
    set_ops(ta, tb_, tc, ts);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_hold_sum"}, sum, prev_sum);
    check({tag, "_hold_cout"}, cout, prev_cout);
    wait_done(1, cyc, bcyc);
    check({tag, "_latency"}, cyc, WIDTH + 1);
    check({tag, "_busy_cycles"}, bcyc, WIDTH);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    prev_sum  = es;
    prev_cout = ec;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc, bcyc;
    reset = 1'b1;
    start = 1'b1;
    set_ops(8'h3C, 8'h42, 1'b0, 1'b0);
    prev_sum  = '0;
    prev_cout = 1'b0;

    // 1: reset for two cycles with start held high
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // 2, 3: basic adds and carry boundaries
    do_add("add_3c_42", 8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0);
    do_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_add("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);

    // 4: start during RUN is ignored; start held in DONE relaunches immediately
    @(negedge clk);
    set_ops(8'h10, 8'h20, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    set_ops(8'hAA, 8'h55, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", busy, 1);
    wait_done(4, cyc, bcyc);
    check("ign_latency", cyc, WIDTH + 1);
    check("ign_done", done, 1);
    check("ign_sum", sum, 8'h30);
    check("ign_cout", cout, 0);
    set_ops(8'h80, 8'h80, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_no_done", done, 0);
    check("b2b_hold_sum", sum, 8'h30);
    wait_done(1, cyc, bcyc);
    check("b2b_latency", cyc, WIDTH + 1);
    check("b2b_sum", sum, 8'h00);
    check("b2b_cout", cout, 1);
    prev_sum  = 8'h00;
    prev_cout = 1'b1;
    @(negedge clk);

    // give a non-zero result so the abort below is visible on the outputs
    do_add("add_pre_abort", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);

    // 5: reset in the 4th RUN cycle aborts with no done
    @(negedge clk);
    set_ops(8'h0F, 8'h01, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    bcyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) bcyc++;
    end
    check("abort_quiet", bcyc, 0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    do_add("add_after_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    // 6: subtraction; cin is ignored when sub=1
    do_add("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    do_add("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    do_add("sub0_add", 8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
